ltc2208_ctrl_seq: RTL and testbench

Control sequencer for the LTC2208 ADC front end. It owns the ADC static control pins (RAND, DITHER, PGA, SHDN) and applies configuration requests from the register interface through a valid/ready handshake. Around every real configuration change it blanks downstream data for a fixed settle time, covering the ADC pipeline and the derandomiser register stages. It also monitors the ADC overrange pin. adc_rand drives both the ADC RAND pin and the derandomiser rand_sel, so the two can never disagree.

---
 rtl/ltc2208_ctrl_seq.sv | 166 ++++++++++++++++
 tb/tb_ltc2208_ctrl_seq.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ltc2208_ctrl_seq.sv
// LTC2208 front-end control sequencer.
// Owns the static ADC control pins, applies configuration requests through a
// valid/ready handshake, blanks downstream data while the ADC pipeline and the
// derandomiser settle, and monitors/stretches the ADC overrange pin.
module ltc2208_ctrl_seq #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned WAKE_CYCLES   = 4096,
    parameter int unsigned OVR_HOLD      = 1024
) (
    input  logic        clk,
    input  logic        rst,
    // Configuration request
    input  logic        cfg_rand,
    input  logic        cfg_dither,
    input  logic        cfg_pga,
    input  logic        cfg_shdn,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    // ADC static pins (adc_rand also drives the derandomiser select)
    output logic        adc_rand,
    output logic        adc_dither,
    output logic        adc_pga,
    output logic        adc_shdn,
    // Data qualification and overrange monitor
    input  logic        adc_ovr,
    output logic        data_en,
    output logic        ovr_flag,
    output logic [15:0] ovr_count,
    input  logic        ovr_clr
);

    // Counter reload values; the settle counter holds "cycles remaining - 1".
    localparam logic [15:0] SettleLoad = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] WakeLoad   = 16'(WAKE_CYCLES - 1);
    localparam logic [15:0] HoldLoad   = 16'(OVR_HOLD);
    localparam logic [15:0] CountMax   = 16'hFFFF;

    localparam logic [1:0] StSettle = 2'd0;
    localparam logic [1:0] StRun    = 2'd1;
    localparam logic [1:0] StShdn   = 2'd2;

    // Pin vector layout: {shdn, pga, dither, rand}
    localparam int unsigned PinShdn = 3;

    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  pins_q, pins_d;
    logic        data_en_q;
    logic        cfg_ready_q;
    logic [3:0]  cfg_pins;
    logic        accept;

    logic        ovr_q;
    logic        ovr_hit;
    logic [15:0] hold_q, hold_d;
    logic        ovr_flag_q;
    logic [15:0] ovr_count_q, ovr_count_d;

    assign cfg_pins = {cfg_shdn, cfg_pga, cfg_dither, cfg_rand};
    assign accept   = cfg_valid & cfg_ready_q;

    // Sequencer next state: settle countdown, request decode, pin updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pins_d  = pins_q;
        case (state_q)
            StSettle: begin
                if (cnt_q == 16'd0) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StRun: begin
                if (accept) begin
                    if (cfg_pins[PinShdn]) begin
                        pins_d  = cfg_pins;
                        state_d = StShdn;
                    end else if (cfg_pins != pins_q) begin
                        pins_d  = cfg_pins;
                        cnt_d   = SettleLoad;
                        state_d = StSettle;
                    end
                    // Identical request: nothing moves, no blanking.
                end
            end
            StShdn: begin
                if (accept) begin
                    pins_d = cfg_pins;
                    if (!cfg_pins[PinShdn]) begin
                        cnt_d   = WakeLoad;
                        state_d = StSettle;
                    end
                end
            end
            default: begin
                // Unreachable encoding: recover through a full wake blanking.
                state_d = StSettle;
                cnt_d   = WakeLoad;
            end
        endcase
    end

    // Sequencer registers; data_en/cfg_ready are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StSettle;
            cnt_q       <= WakeLoad;
            pins_q      <= 4'b0000;
            data_en_q   <= 1'b0;
            cfg_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pins_q      <= pins_d;
            data_en_q   <= (state_d == StRun);
            cfg_ready_q <= (state_d != StSettle);
        end
    end

    // Overrange only counts while samples are valid downstream.
    assign ovr_hit = ovr_q & data_en_q;

    // Overrange next state: hold stretch and saturating counter with clear.
    always_comb begin
        hold_d      = hold_q;
        ovr_count_d = ovr_count_q;
        if (ovr_hit) begin
            hold_d = HoldLoad;
        end else if (hold_q != 16'd0) begin
            hold_d = hold_q - 16'd1;
        end
        if (ovr_clr) begin
            // A hit coinciding with the clear survives as a count of one.
            ovr_count_d = {15'd0, ovr_hit};
        end else if (ovr_hit && (ovr_count_q != CountMax)) begin
            ovr_count_d = ovr_count_q + 16'd1;
        end
    end

    // Overrange registers; the flag tracks the updated hold counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_q       <= 1'b0;
            hold_q      <= 16'd0;
            ovr_flag_q  <= 1'b0;
            ovr_count_q <= 16'd0;
        end else begin
            ovr_q       <= adc_ovr;
            hold_q      <= hold_d;
            ovr_flag_q  <= (hold_d != 16'd0);
            ovr_count_q <= ovr_count_d;
        end
    end

    assign cfg_ready  = cfg_ready_q;
    assign data_en    = data_en_q;
    assign adc_rand   = pins_q[0];
    assign adc_dither = pins_q[1];
    assign adc_pga    = pins_q[2];
    assign adc_shdn   = pins_q[3];
    assign ovr_flag   = ovr_flag_q;
    assign ovr_count  = ovr_count_q;

endmodule

// File: tb/tb_ltc2208_ctrl_seq.sv
// Self-checking bench for ltc2208_ctrl_seq.
// Accepted requests push expected pin values into a queue; a monitor pops and
// compares them against the ADC pins after each handshake edge.
module tb_ltc2208_ctrl_seq;

    localparam int unsigned Settle = 16;
    localparam int unsigned Wake   = 32;
    localparam int unsigned Hold   = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_rand = 1'b0, cfg_dither = 1'b0, cfg_pga = 1'b0, cfg_shdn = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic        adc_rand, adc_dither, adc_pga, adc_shdn;
    logic        adc_ovr = 1'b0;
    logic        data_en;
    logic        ovr_flag;
    logic [15:0] ovr_count;
    logic        ovr_clr = 1'b0;
    logic [3:0]  adc_pins;
    logic [3:0]  mon_exp;

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_q[$];

    assign adc_pins = {adc_shdn, adc_pga, adc_dither, adc_rand};

    ltc2208_ctrl_seq #(
        .SETTLE_CYCLES(Settle),
        .WAKE_CYCLES  (Wake),
        .OVR_HOLD     (Hold)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_rand  (cfg_rand),
        .cfg_dither(cfg_dither),
        .cfg_pga   (cfg_pga),
        .cfg_shdn  (cfg_shdn),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .adc_rand  (adc_rand),
        .adc_dither(adc_dither),
        .adc_pga   (adc_pga),
        .adc_shdn  (adc_shdn),
        .adc_ovr   (adc_ovr),
        .data_en   (data_en),
        .ovr_flag  (ovr_flag),
        .ovr_count (ovr_count),
        .ovr_clr   (ovr_clr)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every handshake edge must update the pins as queued.
    always begin
        @(posedge clk);
        if (!rst && cfg_valid && cfg_ready) begin
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL accept_unexpected: pins got %b, no request queued", adc_pins);
            end else begin
                mon_exp = exp_q.pop_front();
                if (adc_pins !== mon_exp) begin
                    errors++;
                    $display("FAIL accept_pins: got %b want %b", adc_pins, mon_exp);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request {shdn,pga,dither,rand}; returns cycles spent stalled.
    task automatic send_req(input logic [3:0] p, output int waited);
        logic r;
        waited = 0;
        {cfg_shdn, cfg_pga, cfg_dither, cfg_rand} = p;
        cfg_valid = 1'b1;
        exp_q.push_back(p);
        for (int i = 0; i < 500; i++) begin
            r = cfg_ready;
            step();
            if (r) break;
            waited++;
        end
        cfg_valid = 1'b0;
    endtask

    task automatic wait_run(output int n);
        n = 0;
        while (data_en !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        step();
        step();
        checks++;
        if (adc_pins !== 4'b0000) begin
            errors++; $display("FAIL reset_pins: got %b want 0000", adc_pins);
        end
        checks++;
        if (cfg_ready !== 1'b0 || data_en !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: ready %b en %b want 0 0", cfg_ready, data_en);
        end
        checks++;
        if (ovr_count !== 16'd0 || ovr_flag !== 1'b0) begin
            errors++; $display("FAIL reset_ovr: count %0d flag %b want 0 0", ovr_count, ovr_flag);
        end
        rst = 1'b0;
        wait_run(n);
        checks++;
        if (n !== 32) begin
            errors++; $display("FAIL reset_wake_len: got %0d want 32", n);
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready_up: got %b want 1", cfg_ready);
        end
    endtask

    task automatic test_settle();
        int w;
        int n;
        send_req(4'b0001, w);
        checks++;
        if (w !== 0) begin
            errors++; $display("FAIL settle_accept_wait: got %0d want 0", w);
        end
        checks++;
        if (data_en !== 1'b0 || cfg_ready !== 1'b0) begin
            errors++; $display("FAIL settle_blank: en %b ready %b want 0 0", data_en, cfg_ready);
        end
        // Second request held through SETTLE; stalls for exactly the blanking.
        send_req(4'b0011, w);
        checks++;
        if (w !== 16) begin
            errors++; $display("FAIL settle_len_stall: got %0d want 16", w);
        end
        checks++;
        if (data_en !== 1'b0) begin
            errors++; $display("FAIL settle_second_blank: got %b want 0", data_en);
        end
        wait_run(n);
        checks++;
        if (n !== 16) begin
            errors++; $display("FAIL settle_len_second: got %0d want 16", n);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        for (int i = 0; i < 4; i++) begin
            send_req(4'b0011, w);
            checks++;
            if (w !== 0 || data_en !== 1'b1 || cfg_ready !== 1'b1) begin
                errors++;
                $display("FAIL nochange_%0d: wait %0d en %b ready %b want 0 1 1",
                         i, w, data_en, cfg_ready);
            end
        end
    endtask

    task automatic test_shdn();
        int w;
        int n;
        send_req(4'b1011, w);
        checks++;
        if (data_en !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++; $display("FAIL shdn_enter: en %b ready %b want 0 1", data_en, cfg_ready);
        end
        step(); step(); step();
        checks++;
        if (data_en !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++; $display("FAIL shdn_hold: en %b ready %b want 0 1", data_en, cfg_ready);
        end
        send_req(4'b1111, w);
        checks++;
        if (w !== 0 || data_en !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL shdn_stay: wait %0d en %b ready %b want 0 0 1", w, data_en, cfg_ready);
        end
        send_req(4'b0010, w);
        wait_run(n);
        checks++;
        if (n !== 32) begin
            errors++; $display("FAIL shdn_wake_len: got %0d want 32", n);
        end
        checks++;
        if (adc_dither !== 1'b1 || adc_shdn !== 1'b0) begin
            errors++; $display("FAIL shdn_wake_pins: got %b want 0010", adc_pins);
        end
    endtask

    task automatic test_ovr();
        adc_ovr = 1'b1;
        step();
        checks++;
        if (ovr_count !== 16'd0) begin
            errors++; $display("FAIL ovr_latency0: got %0d want 0", ovr_count);
        end
        step();
        checks++;
        if (ovr_count !== 16'd1 || ovr_flag !== 1'b1) begin
            errors++; $display("FAIL ovr_latency1: count %0d flag %b want 1 1", ovr_count, ovr_flag);
        end
        step();
        adc_ovr = 1'b0;
        step();
        checks++;
        if (ovr_count !== 16'd3) begin
            errors++; $display("FAIL ovr_count3: got %0d want 3", ovr_count);
        end
        for (int i = 0; i < 7; i++) step();
        checks++;
        if (ovr_flag !== 1'b1) begin
            errors++; $display("FAIL ovr_flag_hold: got %b want 1", ovr_flag);
        end
        step();
        checks++;
        if (ovr_flag !== 1'b0) begin
            errors++; $display("FAIL ovr_flag_fall: got %b want 0", ovr_flag);
        end
        // Clear coinciding with an increment keeps that event.
        adc_ovr = 1'b1;
        step();
        adc_ovr = 1'b0;
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        checks++;
        if (ovr_count !== 16'd1) begin
            errors++; $display("FAIL ovr_clr_inc: got %0d want 1", ovr_count);
        end
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        checks++;
        if (ovr_count !== 16'd0) begin
            errors++; $display("FAIL ovr_clr: got %0d want 0", ovr_count);
        end
        adc_ovr = 1'b1;
        for (int i = 0; i < 65535; i++) step();
        checks++;
        if (ovr_count !== 16'hFFFE) begin
            errors++; $display("FAIL ovr_preload: got %h want fffe", ovr_count);
        end
        for (int i = 0; i < 5; i++) step();
        adc_ovr = 1'b0;
        step();
        step();
        checks++;
        if (ovr_count !== 16'hFFFF) begin
            errors++; $display("FAIL ovr_saturate: got %h want ffff", ovr_count);
        end
    endtask

    task automatic test_ovr_in_settle();
        int w;
        int n;
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (ovr_count !== 16'd0 || ovr_flag !== 1'b0) begin
            errors++; $display("FAIL settle_ovr_pre: count %0d flag %b want 0 0", ovr_count, ovr_flag);
        end
        send_req(4'b0000, w);
        adc_ovr = 1'b1;
        for (int i = 0; i < 6; i++) step();
        adc_ovr = 1'b0;
        step();
        step();
        checks++;
        if (ovr_count !== 16'd0 || ovr_flag !== 1'b0 || data_en !== 1'b0) begin
            errors++;
            $display("FAIL settle_ovr_ignored: count %0d flag %b en %b want 0 0 0",
                     ovr_count, ovr_flag, data_en);
        end
        wait_run(n);
        checks++;
        if (n !== 8) begin
            errors++; $display("FAIL settle_ovr_remaining: got %0d want 8", n);
        end
    endtask

    task automatic test_reset_mid_settle();
        int w;
        int n;
        adc_ovr = 1'b1;
        step();
        adc_ovr = 1'b0;
        step();
        checks++;
        if (ovr_count !== 16'd1) begin
            errors++; $display("FAIL mid_pre_count: got %0d want 1", ovr_count);
        end
        send_req(4'b0100, w);
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        checks++;
        if (adc_pins !== 4'b0000 || cfg_ready !== 1'b0 || data_en !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_ctrl: pins %b ready %b en %b want 0000 0 0",
                     adc_pins, cfg_ready, data_en);
        end
        checks++;
        if (ovr_count !== 16'd0 || ovr_flag !== 1'b0) begin
            errors++; $display("FAIL mid_reset_ovr: count %0d flag %b want 0 0", ovr_count, ovr_flag);
        end
        rst = 1'b0;
        wait_run(n);
        checks++;
        if (n !== 32) begin
            errors++; $display("FAIL mid_reset_wake: got %0d want 32", n);
        end
    endtask

    initial begin
        test_reset();
        test_settle();
        test_back_to_back();
        test_shdn();
        test_ovr();
        test_ovr_in_settle();
        test_reset_mid_settle();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
